// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-stage definitions: FSM state encoding and instruction constants
// used by fetch, decode and the PC.
package instr_fetch_unit_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    localparam logic [31:0] ECALL_INSTR = 32'h0000_0073;

    // An ECALL or an all-zero word marks the end of the program image.
    function automatic logic is_end_word(input logic [31:0] w);
        return (w == ECALL_INSTR) || (w == 32'h0000_0000);
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bundle of PC, ROM and decode signals around the fetch unit.
// The slave modport is the fetch unit itself; master is its environment.
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] pc_addr;
    logic              pc_valid;
    logic              pc_ready;
    logic              flush;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic              addr_err;
    logic              program_finished;

    modport master (
        output pc_addr, pc_valid, flush, mem_rdata, instr_ready,
        input  pc_ready, mem_rd_en, mem_addr, instr, instr_pc,
               instr_valid, addr_err, program_finished
    );

    modport slave (
        input  pc_addr, pc_valid, flush, mem_rdata, instr_ready,
        output pc_ready, mem_rd_en, mem_addr, instr, instr_pc,
               instr_valid, addr_err, program_finished
    );

endinterface

// File: rtl/instr_fetch_unit_byte_assembler.sv
// Collects four ROM bytes, least significant first, into a 32-bit word and
// pulses done_o on the edge that captures the last byte.
module ifu_byte_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        cap_en_i,
    input  logic [7:0]  rdata_i,
    output logic [31:0] word_o,
    output logic        done_o
);

    logic [1:0]  cnt_q;
    logic [31:0] word_q;
    logic [31:0] word_d;

    // word_o exposes the word including the byte arriving this cycle, so the
    // caller sees the complete instruction on the done edge.
    always_comb begin
        word_d = word_q;
        if (cap_en_i) begin
            word_d[{cnt_q, 3'b000} +: 8] = rdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 2'd0;
        end else if (clr_i) begin
            cnt_q <= 2'd0;
        end else if (cap_en_i) begin
            cnt_q <= cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        word_q <= word_d;
    end

    assign word_o = word_d;
    assign done_o = cap_en_i && (cnt_q == 2'd3);

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: reads four bytes from a byte-wide synchronous ROM, presents the
// little-endian word to decode and raises a sticky end-of-program flag.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int MEM_BYTES = 128
) (
    input  logic              clk,
    input  logic              rst,
    instr_fetch_unit_if.slave bus
);

    fetch_state_e      state_q;
    logic [1:0]        k_q;
    logic              rd_en_q;
    logic              rd_pend_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] instr_pc_q;
    logic [31:0]       instr_q;
    logic              valid_q;
    logic              err_q;
    logic              pf_q;

    logic              accept;
    logic              bad_addr;
    logic              asm_clr;
    logic              asm_cap;
    logic [31:0]       asm_word;
    logic              asm_done;

    assign accept   = (state_q == IDLE) && !pf_q && bus.pc_valid && !bus.flush;
    assign bad_addr = (bus.pc_addr[1:0] != 2'b00) ||
                      (int'(bus.pc_addr) > MEM_BYTES - 4);

    // A flush also suppresses the byte returning from the ROM this cycle.
    assign asm_clr = (state_q != FETCH) || bus.flush;
    assign asm_cap = rd_pend_q && (state_q == FETCH) && !bus.flush;

    ifu_byte_assembler u_asm (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (asm_clr),
        .cap_en_i (asm_cap),
        .rdata_i  (bus.mem_rdata),
        .word_o   (asm_word),
        .done_o   (asm_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            k_q        <= 2'd0;
            rd_en_q    <= 1'b0;
            rd_pend_q  <= 1'b0;
            addr_q     <= '0;
            instr_pc_q <= '0;
            instr_q    <= 32'h0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            pf_q       <= 1'b0;
        end else begin
            rd_pend_q <= rd_en_q && !bus.flush;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        instr_pc_q <= bus.pc_addr;
                        if (bad_addr) begin
                            state_q <= HOLD;
                            instr_q <= NOP_INSTR;
                            err_q   <= 1'b1;
                            valid_q <= 1'b1;
                        end else begin
                            state_q <= FETCH;
                            rd_en_q <= 1'b1;
                            addr_q  <= bus.pc_addr;
                            k_q     <= 2'd1;
                        end
                    end
                end
                FETCH: begin
                    if (bus.flush) begin
                        state_q <= IDLE;
                        rd_en_q <= 1'b0;
                    end else begin
                        // k_q wrapping back to 0 means all four reads are out.
                        if (rd_en_q) begin
                            if (k_q == 2'd0) begin
                                rd_en_q <= 1'b0;
                            end else begin
                                addr_q <= instr_pc_q + ADDR_W'(k_q);
                                k_q    <= k_q + 2'd1;
                            end
                        end
                        if (asm_done) begin
                            state_q <= HOLD;
                            instr_q <= asm_word;
                            valid_q <= 1'b1;
                            err_q   <= 1'b0;
                            if (is_end_word(asm_word)) begin
                                pf_q <= 1'b1;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (bus.flush || bus.instr_ready) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        err_q   <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.pc_ready         = (state_q == IDLE) && !pf_q;
    assign bus.mem_rd_en        = rd_en_q;
    assign bus.mem_addr         = addr_q;
    assign bus.instr            = instr_q;
    assign bus.instr_pc         = instr_pc_q;
    assign bus.instr_valid      = valid_q;
    assign bus.addr_err         = err_q;
    assign bus.program_finished = pf_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a behavioural synchronous byte ROM.
module tb_instr_fetch_unit;
    import instr_fetch_unit_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    logic [7:0] rom [256];

    instr_fetch_unit_if #(.ADDR_W(8)) bus ();

    instr_fetch_unit #(.ADDR_W(8), .MEM_BYTES(128)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rdata <= rom[bus.mem_addr];
    end

    task automatic test_reset();
        total++;
        if (bus.pc_ready !== 1'b1 || bus.instr_valid !== 1'b0 || bus.mem_rd_en !== 1'b0 ||
            bus.addr_err !== 1'b0 || bus.program_finished !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl: ready=%b valid=%b rd=%b err=%b pf=%b, want 1 0 0 0 0",
                     bus.pc_ready, bus.instr_valid, bus.mem_rd_en, bus.addr_err, bus.program_finished);
        end
        total++;
        if (bus.instr !== 32'h0 || bus.instr_pc !== 8'h00 || bus.mem_addr !== 8'h00) begin
            bad++;
            $display("FAIL reset_data: instr=%h pc=%h maddr=%h, want 0 0 0",
                     bus.instr, bus.instr_pc, bus.mem_addr);
        end
    endtask

    task automatic test_fetch_hold();
        @(negedge clk); bus.pc_addr = 8'h00; bus.pc_valid = 1'b1;
        @(negedge clk); bus.pc_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (bus.mem_rd_en !== 1'b1 || bus.mem_addr !== 8'(k) || bus.pc_ready !== 1'b0 ||
                bus.instr_valid !== 1'b0) begin
                bad++;
                $display("FAIL fetch_read k=%0d: rd=%b addr=%h ready=%b valid=%b, want 1 %h 0 0",
                         k, bus.mem_rd_en, bus.mem_addr, bus.pc_ready, bus.instr_valid, 8'(k));
            end
            @(negedge clk);
        end
        total++;
        if (bus.mem_rd_en !== 1'b0 || bus.instr_valid !== 1'b0) begin
            bad++;
            $display("FAIL fetch_cycle4: rd=%b valid=%b, want 0 0", bus.mem_rd_en, bus.instr_valid);
        end
        @(negedge clk);
        total++;
        if (bus.instr_valid !== 1'b1 || bus.instr !== 32'h00A00513 || bus.instr_pc !== 8'h00 ||
            bus.addr_err !== 1'b0 || bus.program_finished !== 1'b0) begin
            bad++;
            $display("FAIL fetch_word: valid=%b instr=%h pc=%h err=%b pf=%b, want 1 00a00513 00 0 0",
                     bus.instr_valid, bus.instr, bus.instr_pc, bus.addr_err, bus.program_finished);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (bus.instr_valid !== 1'b1 || bus.instr !== 32'h00A00513 || bus.pc_ready !== 1'b0) begin
                bad++;
                $display("FAIL hold_stable i=%0d: valid=%b instr=%h ready=%b, want 1 00a00513 0",
                         i, bus.instr_valid, bus.instr, bus.pc_ready);
            end
        end
        bus.instr_ready = 1'b1;
        @(negedge clk); bus.instr_ready = 1'b0;
        total++;
        if (bus.instr_valid !== 1'b0 || bus.pc_ready !== 1'b1) begin
            bad++;
            $display("FAIL hold_release: valid=%b ready=%b, want 0 1", bus.instr_valid, bus.pc_ready);
        end
    endtask

    task automatic test_addr_err(input logic [7:0] a);
        @(negedge clk); bus.pc_addr = a; bus.pc_valid = 1'b1;
        @(negedge clk); bus.pc_valid = 1'b0;
        total++;
        if (bus.instr_valid !== 1'b1 || bus.instr !== 32'h00000013 || bus.addr_err !== 1'b1 ||
            bus.instr_pc !== a || bus.mem_rd_en !== 1'b0) begin
            bad++;
            $display("FAIL addr_err a=%h: valid=%b instr=%h err=%b pc=%h rd=%b, want 1 00000013 1 %h 0",
                     a, bus.instr_valid, bus.instr, bus.addr_err, bus.instr_pc, bus.mem_rd_en, a);
        end
        bus.instr_ready = 1'b1;
        @(negedge clk); bus.instr_ready = 1'b0;
        total++;
        if (bus.instr_valid !== 1'b0 || bus.mem_rd_en !== 1'b0 || bus.pc_ready !== 1'b1) begin
            bad++;
            $display("FAIL addr_err_done a=%h: valid=%b rd=%b ready=%b, want 0 0 1",
                     a, bus.instr_valid, bus.mem_rd_en, bus.pc_ready);
        end
    endtask

    task automatic test_boundary();
        @(negedge clk); bus.pc_addr = 8'h7C; bus.pc_valid = 1'b1;
        @(negedge clk); bus.pc_valid = 1'b0;
        total++;
        if (bus.mem_rd_en !== 1'b1 || bus.mem_addr !== 8'h7C) begin
            bad++;
            $display("FAIL boundary_read: rd=%b addr=%h, want 1 7c", bus.mem_rd_en, bus.mem_addr);
        end
        repeat (5) @(negedge clk);
        total++;
        if (bus.instr_valid !== 1'b1 || bus.instr !== 32'h44332211 || bus.addr_err !== 1'b0) begin
            bad++;
            $display("FAIL boundary_word: valid=%b instr=%h err=%b, want 1 44332211 0",
                     bus.instr_valid, bus.instr, bus.addr_err);
        end
        bus.instr_ready = 1'b1;
        @(negedge clk); bus.instr_ready = 1'b0;
    endtask

    task automatic test_flush();
        // Flush in IDLE blocks a simultaneous request.
        @(negedge clk); bus.pc_addr = 8'h00; bus.pc_valid = 1'b1; bus.flush = 1'b1;
        @(negedge clk); bus.pc_valid = 1'b0; bus.flush = 1'b0;
        total++;
        if (bus.mem_rd_en !== 1'b0 || bus.pc_ready !== 1'b1) begin
            bad++;
            $display("FAIL flush_idle: rd=%b ready=%b, want 0 1", bus.mem_rd_en, bus.pc_ready);
        end
        bus.pc_addr = 8'h04; bus.pc_valid = 1'b1;
        @(negedge clk); bus.pc_valid = 1'b0;
        @(negedge clk); bus.flush = 1'b1;
        @(negedge clk); bus.flush = 1'b0;
        total++;
        if (bus.mem_rd_en !== 1'b0 || bus.instr_valid !== 1'b0 || bus.pc_ready !== 1'b1) begin
            bad++;
            $display("FAIL flush_fetch: rd=%b valid=%b ready=%b, want 0 0 1",
                     bus.mem_rd_en, bus.instr_valid, bus.pc_ready);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            total++;
            if (bus.instr_valid !== 1'b0) begin
                bad++;
                $display("FAIL flush_quiet i=%0d: valid=%b, want 0", i, bus.instr_valid);
            end
        end
        bus.pc_addr = 8'h04; bus.pc_valid = 1'b1;
        @(negedge clk); bus.pc_valid = 1'b0;
        repeat (5) @(negedge clk);
        total++;
        if (bus.instr_valid !== 1'b1 || bus.instr !== 32'h00100093 || bus.instr_pc !== 8'h04) begin
            bad++;
            $display("FAIL flush_refetch: valid=%b instr=%h pc=%h, want 1 00100093 04",
                     bus.instr_valid, bus.instr, bus.instr_pc);
        end
        bus.instr_ready = 1'b1;
        @(negedge clk); bus.instr_ready = 1'b0;
    endtask

    task automatic test_ecall();
        @(negedge clk); bus.pc_addr = 8'h10; bus.pc_valid = 1'b1;
        @(negedge clk); bus.pc_valid = 1'b0;
        repeat (4) @(negedge clk);
        total++;
        if (bus.program_finished !== 1'b0 || bus.instr_valid !== 1'b0) begin
            bad++;
            $display("FAIL ecall_early: pf=%b valid=%b, want 0 0", bus.program_finished, bus.instr_valid);
        end
        @(negedge clk);
        total++;
        if (bus.program_finished !== 1'b1 || bus.instr_valid !== 1'b1 || bus.instr !== 32'h00000073 ||
            bus.pc_ready !== 1'b0) begin
            bad++;
            $display("FAIL ecall_word: pf=%b valid=%b instr=%h ready=%b, want 1 1 00000073 0",
                     bus.program_finished, bus.instr_valid, bus.instr, bus.pc_ready);
        end
        bus.instr_ready = 1'b1;
        @(negedge clk); bus.instr_ready = 1'b0;
        total++;
        if (bus.program_finished !== 1'b1 || bus.instr_valid !== 1'b0 || bus.pc_ready !== 1'b0) begin
            bad++;
            $display("FAIL ecall_sticky: pf=%b valid=%b ready=%b, want 1 0 0",
                     bus.program_finished, bus.instr_valid, bus.pc_ready);
        end
        bus.pc_addr = 8'h00; bus.pc_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (bus.mem_rd_en !== 1'b0 || bus.instr_valid !== 1'b0) begin
                bad++;
                $display("FAIL ecall_block i=%0d: rd=%b valid=%b, want 0 0", i, bus.mem_rd_en, bus.instr_valid);
            end
        end
        bus.pc_valid = 1'b0;
    endtask

    task automatic test_rst_mid();
        @(negedge clk); #1 rst = 1'b1;
        #1;
        total++;
        if (bus.program_finished !== 1'b0 || bus.pc_ready !== 1'b1 || bus.instr !== 32'h0) begin
            bad++;
            $display("FAIL rst_clear_pf: pf=%b ready=%b instr=%h, want 0 1 0",
                     bus.program_finished, bus.pc_ready, bus.instr);
        end
        @(negedge clk); rst = 1'b0;
        bus.pc_addr = 8'h04; bus.pc_valid = 1'b1;
        @(negedge clk); bus.pc_valid = 1'b0;
        @(negedge clk); #2 rst = 1'b1;
        #1;
        total++;
        if (bus.mem_rd_en !== 1'b0 || bus.mem_addr !== 8'h00 || bus.pc_ready !== 1'b1 ||
            bus.instr_pc !== 8'h00 || bus.instr_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_fetch: rd=%b maddr=%h ready=%b pc=%h valid=%b, want 0 00 1 00 0",
                     bus.mem_rd_en, bus.mem_addr, bus.pc_ready, bus.instr_pc, bus.instr_valid);
        end
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            total++;
            if (bus.instr_valid !== 1'b0 || bus.mem_rd_en !== 1'b0) begin
                bad++;
                $display("FAIL rst_lost i=%0d: valid=%b rd=%b, want 0 0", i, bus.instr_valid, bus.mem_rd_en);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
        {rom[3], rom[2], rom[1], rom[0]}         = 32'h00A00513;
        {rom[7], rom[6], rom[5], rom[4]}         = 32'h00100093;
        {rom[19], rom[18], rom[17], rom[16]}     = 32'h00000073;
        {rom[127], rom[126], rom[125], rom[124]} = 32'h44332211;
        rst             = 1'b1;
        bus.pc_addr     = 8'h00;
        bus.pc_valid    = 1'b0;
        bus.flush       = 1'b0;
        bus.instr_ready = 1'b0;
        @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_fetch_hold();
        test_addr_err(8'h06);
        test_addr_err(8'h80);
        test_boundary();
        test_flush();
        test_ecall();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
